// File: rtl/m_decode_ctrl.sv
// rtl/m_decode_ctrl.sv - decode-stage instruction FIFO and RUN/HALT controller (optional DECODE_CTRL_PERF_EN perf counters)
module m_decode_ctrl #(
    parameter  int DEPTH = 2,
    parameter  int XLEN  = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            resume,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [31:0]     dec_instruction,
    input  logic            dec_illegal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            halted,
    output logic [XLEN-1:0] fault_pc
`ifdef DECODE_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [31:0]       instr_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              has_entry;
    logic              push;
    logic              pop;
    logic              drop;
    logic              halt_enter;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshakes, head presentation and next-state selection
    always_comb begin
        has_entry       = (count != '0);
        in_ready        = (count < CNT_W'(DEPTH)) && (state == S_RUN) && !flush;
        push            = in_valid && in_ready;
        out_valid       = has_entry && (state == S_RUN) && !dec_illegal;
        pop             = out_valid && out_ready;
        drop            = (state == S_HALT) && resume && !flush && has_entry;
        dec_instruction = has_entry ? instr_mem[rd_ptr] : NOP;
        out_pc          = has_entry ? pc_mem[rd_ptr] : '0;
        halted          = (state == S_HALT);
        next_state      = state;
        case (state)
            S_RUN:  if (has_entry && dec_illegal && !flush) next_state = S_HALT;
            S_HALT: if (flush || resume)                   next_state = S_RUN;
            default: next_state = S_RUN;
        endcase
        halt_enter      = (state == S_RUN) && (next_state == S_HALT);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RUN;
        else        state <= next_state;
    end

    // FIFO storage; contents are only visible once count covers them
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // FIFO pointers and occupancy; flush clears regardless of state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)         wr_ptr <= ptr_inc(wr_ptr);
            if (pop || drop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop || drop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Capture the faulting PC when entering HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fault_pc <= '0;
        else if (halt_enter) fault_pc <= pc_mem[rd_ptr];
    end

`ifdef DECODE_CTRL_PERF_EN
    // Saturating issue and back-pressure counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop && (perf_issued != 32'hFFFF_FFFF))
                perf_issued <= perf_issued + 1'b1;
            if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule
